// File: rtl/play_sequencer.sv
// rtl/play_sequencer.sv - rhythm-game session FSM: song select, play/pause/abort, step pacing, result hold
module play_sequencer #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned RESULT_TICKS = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       loader_finish,
  output logic [1:0] song_sel,
  output logic [1:0] cur_song,
  output logic       step_en,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] play_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSE  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam int unsigned RC_W = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESULT_TICKS - 1);

  state_t            st;
  logic [CNT_W-1:0]  prescaler;
  logic [RC_W-1:0]   result_cnt;

  assign state = st;

  // Session FSM; every output is a register updated alongside the state.
  // The prescaler does not advance on the cycle a pause is taken, so the
  // step phase seen on resume is exactly the one held when pausing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      cur_song   <= 2'd1;
      song_sel   <= 2'd0;
      step_en    <= 1'b0;
      busy       <= 1'b0;
      play_count <= 8'd0;
      prescaler  <= '0;
      result_cnt <= '0;
    end else begin
      step_en <= 1'b0;
      case (st)
        S_IDLE: begin
          song_sel <= 2'd0;
          if (btn_start) begin
            st   <= S_ARM;
            busy <= 1'b1;
          end else if (btn_next) begin
            cur_song <= (cur_song == 2'd3) ? 2'd1 : cur_song + 2'd1;
          end
        end
        S_ARM: begin
          prescaler <= '0;
          song_sel  <= cur_song;
          st        <= S_PLAY;
        end
        S_PLAY, S_PAUSE: begin
          if (loader_finish) begin
            st         <= S_RESULT;
            busy       <= 1'b0;
            song_sel   <= 2'd0;
            prescaler  <= '0;
            result_cnt <= '0;
            if (play_count != 8'hFF) play_count <= play_count + 8'd1;
          end else if (st == S_PLAY) begin
            if (btn_start) begin
              st        <= S_IDLE;
              busy      <= 1'b0;
              song_sel  <= 2'd0;
              prescaler <= '0;
            end else if (btn_pause) begin
              st <= S_PAUSE;
            end else if (prescaler == PRE_LAST) begin
              prescaler <= '0;
              step_en   <= 1'b1;
            end else begin
              prescaler <= prescaler + CNT_W'(1);
            end
          end else if (btn_start || btn_pause) begin
            st <= S_PLAY;
          end
        end
        S_RESULT: begin
          song_sel <= 2'd0;
          if (btn_start) begin
            st         <= S_IDLE;
            prescaler  <= '0;
            result_cnt <= '0;
          end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            if (result_cnt == RC_LAST) begin
              st         <= S_IDLE;
              result_cnt <= '0;
            end else begin
              result_cnt <= result_cnt + RC_W'(1);
            end
          end else begin
            prescaler <= prescaler + CNT_W'(1);
          end
        end
        default: begin
          st       <= S_IDLE;
          busy     <= 1'b0;
          song_sel <= 2'd0;
        end
      endcase
    end
  end

endmodule
